// File: rtl/instruction_packer.sv
// Re-assembles decoded instruction fields into a 32-bit word and streams it
// into byte-addressed instruction memory, little-endian, from BASE_ADDR upward.
module instruction_packer #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            opcode,
    input  logic [7:0]            write_reg,
    input  logic [7:0]            read_reg1,
    input  logic [7:0]            read_reg2,
    input  logic [7:0]            immediate,
    input  logic                  use_imm,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_busywait,
    output logic                  instr_done,
    output logic [ADDR_WIDTH-2:0] instr_count,
    output logic                  mem_full
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
    // Pointer of the last instruction slot; its final byte is the top address.
    localparam logic [ADDR_WIDTH-1:0] TOP_PTR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                  r_state, w_state_nx;
    logic [31:0]             r_word, w_word_nx;
    logic [1:0]              r_idx, w_idx_nx;
    logic [ADDR_WIDTH-1:0]   r_ptr, w_ptr_nx;
    logic [ADDR_WIDTH-2:0]   r_count, w_count_nx;
    logic                    r_full, w_full_nx;
    logic                    r_done, w_done_nx;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_ptr   <= BASE;
            r_count <= '0;
            r_full  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_word  <= w_word_nx;
            r_idx   <= w_idx_nx;
            r_ptr   <= w_ptr_nx;
            r_count <= w_count_nx;
            r_full  <= w_full_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_word_nx  = r_word;
        w_idx_nx   = r_idx;
        w_ptr_nx   = r_ptr;
        w_count_nx = r_count;
        w_full_nx  = r_full;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && !r_full) begin
                    w_word_nx  = {opcode, write_reg, read_reg1,
                                  use_imm ? immediate : read_reg2};
                    w_idx_nx   = 2'd0;
                    w_state_nx = WRITE;
                end
            end
            WRITE: begin
                if (!mem_busywait) begin
                    if (r_idx == 2'd3) begin
                        w_idx_nx   = 2'd0;
                        w_count_nx = r_count + (ADDR_WIDTH-1)'(1);
                        w_done_nx  = 1'b1;
                        w_state_nx = IDLE;
                        // Park at the top slot instead of wrapping once memory is full.
                        if (r_ptr == TOP_PTR) begin
                            w_full_nx = 1'b1;
                        end else begin
                            w_ptr_nx = r_ptr + ADDR_WIDTH'(4);
                        end
                    end else begin
                        w_idx_nx = r_idx + 2'd1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    logic [7:0] w_byte;
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            2'd0: w_byte = r_word[7:0];
            2'd1: w_byte = r_word[15:8];
            2'd2: w_byte = r_word[23:16];
            2'd3: w_byte = r_word[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    assign in_ready    = (r_state == IDLE) && !r_full;
    assign mem_write   = (r_state == WRITE);
    assign mem_addr    = r_ptr + ADDR_WIDTH'(r_idx);
    assign mem_wdata   = (r_state == WRITE) ? w_byte : 8'h00;
    assign instr_done  = r_done;
    assign instr_count = r_count;
    assign mem_full    = r_full;

endmodule

// File: tb/tb_instruction_packer.sv
// Directed bench for instruction_packer: main instance at default geometry,
// second small instance (ADDR_WIDTH=4, BASE_ADDR=8) for the fill scenario.
module tb_instruction_packer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    always #5 CLK = ~CLK;

    // main DUT
    logic       in_valid = 0, use_imm = 0, mem_busywait = 0;
    logic [7:0] opcode = 0, write_reg = 0, read_reg1 = 0, read_reg2 = 0, immediate = 0;
    logic       in_ready, mem_write, instr_done, mem_full;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [8:0] instr_count;

    instruction_packer #(.ADDR_WIDTH(10), .BASE_ADDR(0)) u_dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .write_reg(write_reg), .read_reg1(read_reg1),
        .read_reg2(read_reg2), .immediate(immediate), .use_imm(use_imm),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busywait(mem_busywait), .instr_done(instr_done),
        .instr_count(instr_count), .mem_full(mem_full)
    );

    // small DUT for the fill scenario
    logic       f_valid = 0, f_busy = 0;
    logic [7:0] f_op = 0, f_wr = 0, f_r1 = 0, f_r2 = 0;
    logic       f_ready, f_write, f_done, f_full;
    logic [3:0] f_addr;
    logic [7:0] f_wdata;
    logic [2:0] f_count;

    instruction_packer #(.ADDR_WIDTH(4), .BASE_ADDR(8)) u_fill (
        .CLK(CLK), .RESET(RESET), .in_valid(f_valid), .in_ready(f_ready),
        .opcode(f_op), .write_reg(f_wr), .read_reg1(f_r1),
        .read_reg2(f_r2), .immediate(8'hEE), .use_imm(1'b0),
        .mem_write(f_write), .mem_addr(f_addr), .mem_wdata(f_wdata),
        .mem_busywait(f_busy), .instr_done(f_done),
        .instr_count(f_count), .mem_full(f_full)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // memory model fed by completed beats of the main DUT
    logic [7:0] mem [0:1023];
    int beats = 0;
    int f_writes = 0;
    always @(posedge CLK) begin
        if (mem_write && !mem_busywait) begin
            mem[mem_addr] = mem_wdata;
            beats++;
        end
        if (f_write) f_writes++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_fields(input logic [7:0] op, input logic [7:0] wr,
                              input logic [7:0] r1, input logic [7:0] r2,
                              input logic [7:0] imm, input logic ui);
        opcode = op; write_reg = wr; read_reg1 = r1; read_reg2 = r2;
        immediate = imm; use_imm = ui;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (mem_write !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mem: write=%b addr=%0d data=%h, need 0/0/00", mem_write, mem_addr, mem_wdata);
        end
        n_tests++;
        if (instr_done !== 1'b0 || instr_count !== 9'd0 || mem_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: done=%b count=%0d full=%b, need 0/0/0", instr_done, instr_count, mem_full);
        end
        @(negedge CLK);
        RESET = 1'b1;
        step();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b need 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        set_fields(8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 1'b0);
        in_valid = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (mem_write !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== exp_d[i]) begin
                n_fail++;
                $display("FAIL basic_beat%0d: write=%b addr=%0d data=%h, need 1/%0d/%h",
                         i, mem_write, mem_addr, mem_wdata, i, exp_d[i]);
            end
            step();
        end
        n_tests++;
        if (instr_done !== 1'b1 || in_ready !== 1'b1 || mem_write !== 1'b0 || instr_count !== 9'd1) begin
            n_fail++;
            $display("FAIL basic_done: done=%b ready=%b write=%b count=%0d, need 1/1/0/1",
                     instr_done, in_ready, mem_write, instr_count);
        end
        step();
        n_tests++;
        if (instr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: done=%b need 0", instr_done);
        end
    endtask

    task automatic test_imm();
        logic [7:0] exp_d [4] = '{8'hAB, 8'hDE, 8'hBC, 8'h9A};
        set_fields(8'h9A, 8'hBC, 8'hDE, 8'h78, 8'hAB, 1'b1);
        in_valid = 1;
        step();
        in_valid = 0;
        set_fields(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (mem_write !== 1'b1 || mem_addr !== 10'(4 + i) || mem_wdata !== exp_d[i]) begin
                n_fail++;
                $display("FAIL imm_beat%0d: write=%b addr=%0d data=%h, need 1/%0d/%h",
                         i, mem_write, mem_addr, mem_wdata, 4 + i, exp_d[i]);
            end
            step();
        end
        n_tests++;
        if (instr_done !== 1'b1 || instr_count !== 9'd2 || mem[4] !== 8'hAB) begin
            n_fail++;
            $display("FAIL imm_done: done=%b count=%0d mem4=%h, need 1/2/ab", instr_done, instr_count, mem[4]);
        end
    endtask

    task automatic test_stall();
        int b0;
        b0 = beats;
        set_fields(8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 1'b0);
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        step();
        mem_busywait = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_busywait = 0;
            n_tests++;
            if (mem_write !== 1'b1 || mem_addr !== 10'd10 || mem_wdata !== 8'h22 || instr_done !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: write=%b addr=%0d data=%h done=%b, need 1/10/22/0",
                         i, mem_write, mem_addr, mem_wdata, instr_done);
            end
            step();
        end
        n_tests++;
        if (mem_write !== 1'b1 || mem_addr !== 10'd11 || mem_wdata !== 8'h11 || instr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_last: write=%b addr=%0d data=%h done=%b, need 1/11/11/0",
                     mem_write, mem_addr, mem_wdata, instr_done);
        end
        step();
        n_tests++;
        if (instr_done !== 1'b1 || instr_count !== 9'd3 || beats - b0 !== 4) begin
            n_fail++;
            $display("FAIL stall_done: done=%b count=%0d beats=%0d, need 1/3/4", instr_done, instr_count, beats - b0);
        end
        n_tests++;
        if ({mem[11], mem[10], mem[9], mem[8]} !== 32'h11223344) begin
            n_fail++;
            $display("FAIL stall_mem: word=%h need 11223344", {mem[11], mem[10], mem[9], mem[8]});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        set_fields(8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 1'b0);
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        step();
        RESET = 0;
        #1;
        n_tests++;
        if (mem_write !== 1'b0 || mem_addr !== 10'd0 || instr_count !== 9'd0) begin
            n_fail++;
            $display("FAIL rstmid_abort: write=%b addr=%0d count=%0d, need 0/0/0", mem_write, mem_addr, instr_count);
        end
        step();
        RESET = 1;
        step();
        set_fields(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 1'b0);
        in_valid = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (mem_write !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== exp_d[i]) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: write=%b addr=%0d data=%h, need 1/%0d/%h",
                         i, mem_write, mem_addr, mem_wdata, i, exp_d[i]);
            end
            step();
        end
        n_tests++;
        if (instr_done !== 1'b1 || instr_count !== 9'd1) begin
            n_fail++;
            $display("FAIL rstmid_count: done=%b count=%0d, need 1/1", instr_done, instr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3] = '{32'h01020304, 32'hA0B0C0D0, 32'h5A6B7C8D};
        logic [31:0] w;
        opcode = 8'h01; write_reg = 8'h02; read_reg1 = 8'h03; read_reg2 = 8'h04; use_imm = 0;
        in_valid = 1;
        for (int n = 0; n < 3; n++) begin
            step();
            // next field set is presented during WRITE and taken at the next IDLE cycle
            if (n < 2) begin
                w = words[n + 1];
                opcode = w[31:24]; write_reg = w[23:16]; read_reg1 = w[15:8]; read_reg2 = w[7:0];
            end else begin
                in_valid = 0;
            end
            for (int i = 0; i < 4; i++) begin
                w = words[n];
                n_tests++;
                if (mem_write !== 1'b1 || mem_addr !== 10'(4 + 4 * n + i) || mem_wdata !== w[8*i +: 8]) begin
                    n_fail++;
                    $display("FAIL b2b_i%0d_beat%0d: write=%b addr=%0d data=%h, need 1/%0d/%h",
                             n, i, mem_write, mem_addr, mem_wdata, 4 + 4 * n + i, w[8*i +: 8]);
                end
                step();
                if (i < 3) continue;
            end
            // IDLE cycle carrying the done pulse; re-acceptance happens at its end
            n_tests++;
            if (instr_done !== 1'b1 || in_ready !== 1'b1 || mem_write !== 1'b0 || instr_count !== 9'(2 + n)) begin
                n_fail++;
                $display("FAIL b2b_done%0d: done=%b ready=%b write=%b count=%0d, need 1/1/0/%0d",
                         n, instr_done, in_ready, mem_write, instr_count, 2 + n);
            end
        end
        step();
        n_tests++;
        if (mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop: write=%b need 0", mem_write);
        end
    endtask

    task automatic test_fill();
        int wc;
        for (int n = 0; n < 2; n++) begin
            f_op = 8'(8'h10 + n); f_wr = 8'h20; f_r1 = 8'h30; f_r2 = 8'(8'h40 + n);
            f_valid = 1;
            step();
            f_valid = 0;
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (f_write !== 1'b1 || f_addr !== 4'(8 + 4 * n + i)) begin
                    n_fail++;
                    $display("FAIL fill_i%0d_beat%0d: write=%b addr=%0d, need 1/%0d",
                             n, i, f_write, f_addr, 8 + 4 * n + i);
                end
                step();
            end
            n_tests++;
            if (f_done !== 1'b1 || f_full !== (n == 1) || f_ready !== (n == 0) || f_count !== 3'(n + 1)) begin
                n_fail++;
                $display("FAIL fill_done%0d: done=%b full=%b ready=%b count=%0d, need 1/%0d/%0d/%0d",
                         n, f_done, f_full, f_ready, f_count, n == 1, n == 0, n + 1);
            end
        end
        wc = f_writes;
        f_valid = 1;
        for (int i = 0; i < 8; i++) step();
        f_valid = 0;
        n_tests++;
        if (f_writes - wc !== 0 || f_full !== 1'b1 || f_ready !== 1'b0 || f_count !== 3'd2) begin
            n_fail++;
            $display("FAIL fill_blocked: writes=%0d full=%b ready=%b count=%0d, need 0/1/0/2",
                     f_writes - wc, f_full, f_ready, f_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_packer.md
# instruction_packer

Packs decoded instruction fields (opcode, destination register, two source registers or immediate) back into the 32-bit CPU instruction word and writes it, one byte per beat, into the byte-addressed instruction memory. It is the inverse of the CPU's instruction splitter. It sits between the program loader / test harness and the instruction memory write port, and fills memory sequentially from `BASE_ADDR` until the memory is full.

## Interface
- `ADDR_WIDTH`, 10: instruction-memory byte address width.
- `BASE_ADDR`, 0: first byte address written; must be a multiple of 4 and less than 2^ADDR_WIDTH.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RESET`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: field set on the inputs is valid.
- `in_ready`  out  1: packer can accept a field set.
- `opcode`  in  8: placed in word bits [31:24].
- `write_reg`  in  8: placed in word bits [23:16].
- `read_reg1`  in  8: placed in word bits [15:8].
- `read_reg2`  in  8: placed in bits [7:0] when `use_imm`=0.
- `immediate`  in  8: placed in bits [7:0] when `use_imm`=1.
- `use_imm`  in  1: selects `immediate` or `read_reg2` for bits [7:0].
- `mem_write`  out  1: byte write request to instruction memory.
- `mem_addr`  out  ADDR_WIDTH: byte address of the current write.
- `mem_wdata`  out  8: byte being written.
- `mem_busywait`  in  1: memory stall; a beat completes only in a cycle where `mem_write`=1 and `mem_busywait`=0.
- `instr_done`  out  1: one-cycle pulse after all 4 bytes of an instruction are written.
- `instr_count`  out  ADDR_WIDTH-1: number of instructions fully written since reset.
- `mem_full`  out  1: no room for another instruction.

## Operation
- States are IDLE and WRITE.
- IDLE:
  - `in_ready` = !`mem_full`.
  - On `in_valid` && `in_ready`, latch the word {opcode, write_reg, read_reg1, use_imm ? immediate : read_reg2}.
  - Set byte index to 0 and go to WRITE.
  - Inputs are ignored at all other times.
- WRITE:
  - `in_ready`=0 and `mem_write`=1.
  - `mem_addr` = ptr + idx. `mem_wdata` = word byte idx, in little-endian order: idx0 = bits[7:0] … idx3 = bits[31:24].
  - A completed beat increments idx.
  - While `mem_busywait`=1, idx, `mem_addr` and `mem_wdata` hold.
  - When beat idx3 completes:
    - ptr += 4.
    - `instr_count` += 1.
    - `instr_done` asserts for one cycle.
    - Return to IDLE.
- Full condition:
  - `mem_full` sets in the same edge that completes the instruction whose last byte is at address 2^ADDR_WIDTH−1.
  - Once set, it stays set until reset. ptr is then not advanced past the top; no address wrap-around ever occurs.
  - Capacity is (2^ADDR_WIDTH − BASE_ADDR)/4 instructions.
- Latched word is stable for the whole WRITE phase; input changes during WRITE have no effect.

## Timing
- Reset (RESET=0, asynchronous), all outputs and state:
  - state=IDLE, ptr=BASE_ADDR.
  - `mem_write`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0.
  - `instr_done`=0, `instr_count`=0, `mem_full`=0.
  - `in_ready`=1 from the first cycle after release.
- Accept at edge k with no stalls:
  - `mem_write`=1 on cycles k+1..k+4, carrying addresses ptr..ptr+3.
  - `instr_done`=1 in cycle k+5, with `in_ready`=1 in the same cycle.
  - Throughput is one instruction per 5 cycles.
- Each cycle of `mem_busywait`=1 during WRITE adds exactly one cycle of latency.
- `mem_busywait` is ignored in IDLE.
- `in_valid` held high continuously is accepted once per IDLE visit.
- Reset asserted mid-WRITE aborts immediately; partial bytes already written stay in memory; ptr returns to BASE_ADDR.
- All outputs are registered, or decoded from registered state only; no input-to-output combinational path.

## Test plan
- Basic pack: opcode=0x12, write_reg=0x34, read_reg1=0x56, read_reg2=0x78, use_imm=0 -> writes (0,0x78), (1,0x56), (2,0x34), (3,0x12) on 4 consecutive cycles; `instr_done` on cycle 5; `instr_count`=1.
- Immediate select: read_reg2=0x78, immediate=0xAB, use_imm=1, second instruction -> byte at addr 4 is 0xAB, not 0x78; addresses are 4..7; `instr_count`=2.
- Stall: `mem_busywait`=1 for 3 cycles during byte idx 2 -> addr and data hold for those 3 cycles; `instr_done` arrives 3 cycles late; no byte is duplicated or skipped.
- Fill: ADDR_WIDTH=4, BASE_ADDR=8, 2 instructions -> second writes 12..15; `mem_full`=1 and `in_ready`=0 thereafter; a further `in_valid` produces no write; `instr_count`=2.
- Reset mid-write: RESET low after byte 1 -> `mem_write`=0 immediately. After release, the next instruction is written at BASE_ADDR and `instr_count` restarts at 1.
- Back-to-back: `in_valid` held high with changing fields -> one accept per IDLE cycle; each word is written intact; no field mixing between instructions.
